// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, lane offset,
// RISC-V funct3 encodings and request classification helpers.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 8192;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] FN3_LB  = 3'd0;
  localparam logic [2:0] FN3_LH  = 3'd1;
  localparam logic [2:0] FN3_LW  = 3'd2;
  localparam logic [2:0] FN3_LBU = 3'd4;
  localparam logic [2:0] FN3_LHU = 3'd5;
  localparam logic [2:0] FN3_SB  = 3'd0;
  localparam logic [2:0] FN3_SH  = 3'd1;
  localparam logic [2:0] FN3_SW  = 3'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    LCAP = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  // Byte lane within a 32-bit word
  typedef logic [1:0] lane_off_t;

  function automatic logic fn3_valid(input logic we, input logic [2:0] fn3);
    if (we) return (fn3 == FN3_SB) || (fn3 == FN3_SH) || (fn3 == FN3_SW);
    return (fn3 == FN3_LB) || (fn3 == FN3_LH) || (fn3 == FN3_LW) ||
           (fn3 == FN3_LBU) || (fn3 == FN3_LHU);
  endfunction

  // size = funct3[1:0]: 0 byte, 1 halfword, 2 word
  function automatic logic needs_split(input logic [1:0] size, input lane_off_t off);
    return ((size == 2'd1) && (off == 2'd3)) ||
           ((size == 2'd2) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering over a 64-bit {hi,lo} word pair: store data
// and strobes are shifted up to the lane offset, load data is shifted down and extended.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lane_off_t   wr_off,
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [63:0] wr_lanes,
  output logic [7:0]  wr_strb,
  input  lane_off_t   rd_off,
  input  logic [2:0]  rd_fn3,
  input  logic [63:0] rd_lanes,
  output logic [31:0] rd_data
);

  logic [3:0]  base_strb;
  logic [31:0] rd_shifted;

  always_comb begin
    case (wr_size)
      2'd0:    base_strb = 4'b0001;
      2'd1:    base_strb = 4'b0011;
      2'd2:    base_strb = 4'b1111;
      default: base_strb = 4'b0000;
    endcase
  end

  // Only 32 bits ever enter the 64-bit view, so a left shift equals the rotate
  assign wr_lanes = {32'd0, wr_data} << {wr_off, 3'b000};
  assign wr_strb  = {4'd0, base_strb} << wr_off;

  assign rd_shifted = 32'(rd_lanes >> {rd_off, 3'b000});

  always_comb begin
    case (rd_fn3)
      FN3_LB:  rd_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      FN3_LH:  rd_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      FN3_LW:  rd_data = rd_shifted;
      FN3_LBU: rd_data = {24'd0, rd_shifted[7:0]};
      FN3_LHU: rd_data = {16'd0, rd_shifted[15:0]};
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a plain strobed word RAM; all outputs are registered.
// Define LSU_MISALIGN_EN to split word-straddling accesses into two word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fn3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        fn3_q, fn3_d;
  lane_off_t         off_q, off_d;
  logic              split_q, split_d;
  logic [ADDR_W-1:0] addr_hi_q, addr_hi_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [3:0]        wstrb_hi_q, wstrb_hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0]       resp_rdata_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_wstrb_d;
  logic [31:0]       mem_wdata_d;

  lane_off_t         req_off;
  logic [ADDR_W-1:0] lo_addr, hi_addr;
  logic              split_req, lo_oob, acc_err;
  logic [63:0]       wr_lanes, rd_lanes;
  logic [7:0]        wr_strb;
  logic [31:0]       ld_data;

  assign req_off   = lane_off_t'(req_addr[1:0]);
  assign lo_addr   = {req_addr[ADDR_W-1:2], 2'b00};
  assign hi_addr   = lo_addr + ADDR_W'(4);
  assign split_req = needs_split(req_fn3[1:0], req_off);
  assign lo_oob    = {1'b0, lo_addr} >= MEM_LIMIT;

`ifdef LSU_MISALIGN_EN
  logic hi_oob;
  assign hi_oob  = split_req && ({1'b0, hi_addr} >= MEM_LIMIT);
  assign acc_err = !fn3_valid(req_we, req_fn3) || lo_oob || hi_oob;
`else
  assign acc_err = !fn3_valid(req_we, req_fn3) || lo_oob || split_req;
`endif

  // The low word always sits in the lower half; unsplit loads see zeros above it
  assign rd_lanes = split_q ? {mem_rdata, lo_q} : {32'd0, mem_rdata};

  lsu_lane_align u_align (
    .wr_off   (req_off),
    .wr_size  (req_fn3[1:0]),
    .wr_data  (req_wdata),
    .wr_lanes (wr_lanes),
    .wr_strb  (wr_strb),
    .rd_off   (off_q),
    .rd_fn3   (fn3_q),
    .rd_lanes (rd_lanes),
    .rd_data  (ld_data)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    fn3_d        = fn3_q;
    off_d        = off_q;
    split_d      = split_q;
    addr_hi_d    = addr_hi_q;
    wdata_hi_d   = wdata_hi_q;
    wstrb_hi_d   = wstrb_hi_q;
    lo_d         = lo_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wstrb_d  = 4'd0;
    mem_wdata_d  = mem_wdata;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          fn3_d       = req_fn3;
          off_d       = req_off;
          split_d     = split_req;
          addr_hi_d   = hi_addr;
          wdata_hi_d  = wr_lanes[63:32];
          wstrb_hi_d  = wr_strb[7:4];
          if (acc_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ACC0;
            mem_en_d   = 1'b1;
            mem_we_d   = req_we;
            mem_addr_d = lo_addr;
            if (req_we) begin
              mem_wstrb_d = wr_strb[3:0];
              mem_wdata_d = wr_lanes[31:0];
            end
          end
        end
      end
      ACC0: begin
        if (split_q) begin
          state_d    = ACC1;
          mem_en_d   = 1'b1;
          mem_we_d   = we_q;
          mem_addr_d = addr_hi_q;
          if (we_q) begin
            mem_wstrb_d = wstrb_hi_q;
            mem_wdata_d = wdata_hi_q;
          end
        end else if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = LCAP;
        end
      end
      ACC1: begin
        // Low word of a split load returns while the high word is requested
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = LCAP;
          lo_d    = mem_rdata;
        end
      end
      LCAP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      fn3_q      <= 3'd0;
      off_q      <= 2'd0;
      split_q    <= 1'b0;
      addr_hi_q  <= '0;
      wdata_hi_q <= 32'd0;
      wstrb_hi_q <= 4'd0;
      lo_q       <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      fn3_q      <= fn3_d;
      off_q      <= off_d;
      split_q    <= split_d;
      addr_hi_q  <= addr_hi_d;
      wdata_hi_q <= wdata_hi_d;
      wstrb_hi_q <= wstrb_hi_d;
      lo_q       <= lo_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wstrb  <= mem_wstrb_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small strobed word-RAM model;
// expectations follow LSU_MISALIGN_EN when it is defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_fn3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(32), .MEM_WORDS(8192)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_fn3    (req_fn3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 64 words, aliased by mem_addr[7:2]; bench preloads through poke
  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'd0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 6'(idx);
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  // Observations of the last transaction, cycle numbers relative to accept T
  int          en_cnt, en_first, resp_cyc;
  logic [31:0] en_addr [2];
  logic [3:0]  en_strb [2];
  logic [31:0] en_wdata [2];
  logic        ready_t1;
  logic [31:0] rd;
  logic        er;

  task automatic issue(input logic we, input logic [2:0] fn3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    en_cnt = 0; en_first = 0; resp_cyc = 0; rd = 32'd0; er = 1'b0; ready_t1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en_addr[k] = 32'd0; en_strb[k] = 4'd0; en_wdata[k] = 32'd0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_fn3 = fn3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10 && resp_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) ready_t1 = req_ready;
      if (mem_en) begin
        if (en_cnt == 0) en_first = cyc;
        if (en_cnt < 2) begin
          en_addr[en_cnt]  = mem_addr;
          en_strb[en_cnt]  = mem_wstrb;
          en_wdata[en_cnt] = mem_wdata;
        end
        en_cnt++;
      end
      if (resp_valid) begin
        resp_cyc = cyc; rd = resp_rdata; er = resp_err;
      end
    end
  endtask

  logic [31:0] saved;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    poke(4, 32'hDEADBEEF);
    poke(8, 32'h11111111);
    poke(16, 32'h44332211);
    poke(17, 32'h88776655);
    poke(0, 32'h7F000000);
    poke(1, 32'h00000081);
    poke(63, 32'h0BADF00D);

    // Aligned word load
    issue(1'b0, FN3_LW, 32'h10, 32'd0);
    check("lw_ready_busy", 32'(ready_t1), 32'd0);
    check("lw_en_cyc", 32'(en_first), 32'd1);
    check("lw_en_cnt", 32'(en_cnt), 32'd1);
    check("lw_addr", en_addr[0], 32'h10);
    check("lw_resp_cyc", 32'(resp_cyc), 32'd3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);

    // Byte/half extension on 0x80FF0000
    poke(4, 32'h80FF0000);
    issue(1'b0, FN3_LB, 32'h13, 32'd0);
    check("lb_rdata", rd, 32'hFFFFFF80);
    issue(1'b0, FN3_LBU, 32'h13, 32'd0);
    check("lbu_rdata", rd, 32'h00000080);
    issue(1'b0, FN3_LH, 32'h12, 32'd0);
    check("lh_rdata", rd, 32'hFFFF80FF);
    issue(1'b0, FN3_LHU, 32'h11, 32'd0);
    check("lhu_off1_rdata", rd, 32'h0000FF00);
    check("lhu_off1_en_cnt", 32'(en_cnt), 32'd1);

    // Halfword and byte stores
    issue(1'b1, FN3_SH, 32'h22, 32'h0000ABCD);
    check("sh_strb", 32'(en_strb[0]), 32'hC);
    check("sh_wdata", en_wdata[0], 32'hABCD0000);
    check("sh_addr", en_addr[0], 32'h20);
    check("sh_resp_cyc", 32'(resp_cyc), 32'd2);
    check("sh_rdata", rd, 32'd0);
    issue(1'b0, FN3_LW, 32'h20, 32'd0);
    check("sh_readback", rd, 32'hABCD1111);
    issue(1'b1, FN3_SB, 32'h27, 32'h123456AA);
    check("sb_strb", 32'(en_strb[0]), 32'h8);
    check("sb_wdata", en_wdata[0], 32'hAA000000);

    // Word-straddling load and store
    issue(1'b0, FN3_LW, 32'h41, 32'd0);
`ifdef LSU_MISALIGN_EN
    check("lw41_en_cnt", 32'(en_cnt), 32'd2);
    check("lw41_addr1", en_addr[1], 32'h44);
    check("lw41_resp_cyc", 32'(resp_cyc), 32'd4);
    check("lw41_rdata", rd, 32'h55443322);
    check("lw41_err", 32'(er), 32'd0);
`else
    check("lw41_en_cnt", 32'(en_cnt), 32'd0);
    check("lw41_resp_cyc", 32'(resp_cyc), 32'd1);
    check("lw41_err", 32'(er), 32'd1);
    check("lw41_rdata", rd, 32'd0);
`endif
    issue(1'b1, FN3_SW, 32'h41, 32'hA1B2C3D4);
`ifdef LSU_MISALIGN_EN
    check("sw41_strb0", 32'(en_strb[0]), 32'hE);
    check("sw41_strb1", 32'(en_strb[1]), 32'h1);
    check("sw41_wdata0", en_wdata[0], 32'hB2C3D400);
    check("sw41_wdata1", en_wdata[1], 32'h000000A1);
    check("sw41_resp_cyc", 32'(resp_cyc), 32'd3);
    issue(1'b0, FN3_LW, 32'h40, 32'd0);
    check("sw41_lo_readback", rd, 32'hB2C3D411);
    issue(1'b0, FN3_LW, 32'h44, 32'd0);
    check("sw41_hi_readback", rd, 32'h887766A1);
`else
    check("sw41_en_cnt", 32'(en_cnt), 32'd0);
    check("sw41_err", 32'(er), 32'd1);
`endif

    // Halfword at offset 3
    issue(1'b0, FN3_LH, 32'h03, 32'd0);
`ifdef LSU_MISALIGN_EN
    check("lh3_resp_cyc", 32'(resp_cyc), 32'd4);
    check("lh3_rdata", rd, 32'hFFFF817F);
    check("lh3_err", 32'(er), 32'd0);
`else
    check("lh3_en_cnt", 32'(en_cnt), 32'd0);
    check("lh3_resp_cyc", 32'(resp_cyc), 32'd1);
    check("lh3_err", 32'(er), 32'd1);
`endif

    // Invalid funct3 and address range boundaries
    issue(1'b0, 3'd3, 32'h10, 32'd0);
    check("ld_fn3_3_err", 32'(er), 32'd1);
    check("ld_fn3_3_en_cnt", 32'(en_cnt), 32'd0);
    check("ld_fn3_3_resp_cyc", 32'(resp_cyc), 32'd1);
    issue(1'b1, 3'd3, 32'h10, 32'd0);
    check("st_fn3_3_err", 32'(er), 32'd1);
    issue(1'b0, FN3_LW, 32'h8000, 32'd0);
    check("oob_err", 32'(er), 32'd1);
    check("oob_en_cnt", 32'(en_cnt), 32'd0);
    issue(1'b0, FN3_LW, 32'h7FFC, 32'd0);
    check("last_word_err", 32'(er), 32'd0);
    check("last_word_rdata", rd, 32'h0BADF00D);
    issue(1'b0, FN3_LB, 32'h7FFF, 32'd0);
    check("last_byte_rdata", rd, 32'h0000000B);
    issue(1'b0, FN3_LH, 32'h7FFF, 32'd0);
    check("hi_oob_err", 32'(er), 32'd1);
    check("hi_oob_en_cnt", 32'(en_cnt), 32'd0);

    // Reset during the second half of a split store
    saved = mem[17];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_fn3 = FN3_SW; req_addr = 32'h41;
    req_wdata = 32'h0F0E0D0C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_no_2nd_write", mem[17], saved);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the data memory port: accepts load/store requests from the execute stage and issues raw word-aligned accesses with byte strobes.
- Performs all byte-lane steering, zero/sign extension and error detection itself, so the memory behind it is a plain strobed word RAM.
- Splits accesses that straddle a word boundary into two sequential word accesses and merges the result.

Parameters:
- ADDR_W, 32, byte address width.
- MEM_WORDS, 8192, memory depth in 32-bit words; addresses at or above MEM_WORDS*4 raise resp_err.

Ports:
- clk  in  1  CPU clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_fn3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; the access was rejected.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write when mem_en is high.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  read word, valid exactly one cycle after a read with mem_en=1.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, state=IDLE.
- All outputs are registered.
- States: IDLE, ACC0, ACC1, LCAP, RESP.
- Accept: in IDLE, when req_valid=1, latch the request (cycle T).
- Error check at accept:
  - Invalid fn3: loads 3/6/7, stores >=3.
  - Address out of range.
  - Misaligned access while the split feature is disabled.
  - On error: go to RESP with resp_err=1, resp_rdata=0, no memory access; resp_valid at T+1.
- Split condition: halfword at offset 3, or word at offset 1, 2 or 3. Halfword at offset 1 fits lanes 1-2 and is not split.
- Aligned load: ACC0 (T+1, mem_en=1, mem_we=0) -> LCAP (T+2, capture mem_rdata) -> RESP (T+3).
- Split load:
  - ACC0 (T+1) issues the low word.
  - ACC1 (T+2) captures the low word and issues word addr+4.
  - LCAP (T+3) captures the high word.
  - RESP (T+4).
- Aligned store: ACC0 (T+1, mem_we=1, strobes per lane) -> RESP (T+2).
- Split store: ACC0 writes the low lanes, ACC1 writes the remaining lanes at addr+4, then RESP at T+3.
- Strobes:
  - SB: 1<<off.
  - SH: 3<<off, truncated to 4 bits in ACC0; the remainder goes in ACC1.
  - SW: 4'hF<<off, split the same way.
- Write data is rotated left by 8*off across the 64-bit {hi,lo} lane view.
- Loads: extract bytes starting at lane off from the merged 64-bit view. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure; the pipeline stalls on req_ready.
- mem_en=0 in every state other than ACC0 and ACC1. mem_wstrb=0 whenever mem_we=0.
- Address wrap: addr+4 wraps modulo 2^ADDR_W. A second word outside the range is flagged at accept.
- Reset mid-operation: immediately returns to IDLE with reset values. The first half of a split store that has already been written is not rolled back.
- req_valid while busy is ignored; the requester must hold the request.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined: split accesses are performed as above.
- Undefined: any split-condition request returns resp_err=1 at T+1 with no memory access. ACC1 is unreachable and may be removed.

Decomposition:
- Package lsu_pkg: state enum typedef lsu_state_t; lane-offset typedef; MEM_WORDS default.
- Reuse the existing FN3_* constants from the shared definitions header.
- One sub-module, lsu_lane_align: combinational 64-bit lane rotate plus sign/zero extension, used for both the store and load paths.

Test Plan:
- LW addr 0x10, memory word 0xDEADBEEF -> mem_en at T+1, mem_addr 0x10; resp_valid at T+3 with rdata 0xDEADBEEF, err 0.
- LB addr 0x13 on word 0x80FF0000 -> rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x22, wdata 0x0000ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCD0000, mem_addr 0x20; resp at T+2.
- With LSU_MISALIGN_EN, LW addr 0x41 with words 0x44332211 @0x40 and 0x88776655 @0x44 -> two reads, rdata 0x55443322 at T+4. SW to the same address writes strobes 4'b1110, then 4'b0001.
- Without LSU_MISALIGN_EN, LH addr 0x03 -> no mem_en, resp_valid at T+1 with err 1. Invalid load fn3 3 -> err 1 in both builds.
- rst_n asserted in ACC1 of a split store -> outputs return to reset values asynchronously, req_ready=1, no second write.
